// File: rtl/pipe_int_mul_varlat.sv
// Variable-latency radix-2^RADIX_BITS shift-add integer multiplier with valid/ready on both sides.
// Define PIPE_INT_MUL_EARLY_TERM_EN to end CALC once the remaining multiplier bits are zero.
module pipe_int_mul_varlat #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [2*WIDTH-1:0]   out_p
);
    localparam int STEPS = WIDTH / RADIX_BITS;
    localparam int SHW   = $clog2(WIDTH) + 1;

    generate
        if ((WIDTH % RADIX_BITS) != 0 || RADIX_BITS < 1) begin : g_bad_radix
            $error("pipe_int_mul_varlat: WIDTH must be a multiple of RADIX_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]            a_mag, b_rem, a_abs, b_abs, b_nxt;
    logic                        neg;
    logic [2*WIDTH-1:0]          acc, acc_nxt, pp_ext;
    logic [WIDTH+RADIX_BITS-1:0] pp;
    logic [SHW-1:0]              shift;
    logic                        accept, calc_last;

    assign accept = in_val & in_rdy;
    assign a_abs  = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_abs  = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;

    // One radix digit of the multiplier per cycle, shifted into place in the accumulator.
    assign pp      = {{RADIX_BITS{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_rem[RADIX_BITS-1:0]};
    assign pp_ext  = (2*WIDTH)'(pp) << shift;
    assign acc_nxt = acc + pp_ext;
    assign b_nxt   = b_rem >> RADIX_BITS;

`ifdef PIPE_INT_MUL_EARLY_TERM_EN
    assign calc_last = (b_nxt == '0);
`else
    localparam int CW = $clog2(STEPS) + 1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (accept)
            cnt <= CW'(STEPS - 1);
        else if (state == CALC && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign calc_last = (cnt == '0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (calc_last) state_nxt = DONE;
            DONE:    if (out_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state == IDLE);
        out_val = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mag <= '0;
            b_rem <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            shift <= '0;
            out_p <= '0;
        end else if (accept) begin
            a_mag <= a_abs;
            b_rem <= b_abs;
            neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc   <= '0;
            shift <= '0;
        end else if (state == CALC) begin
            acc   <= acc_nxt;
            b_rem <= b_nxt;
            shift <= shift + SHW'(RADIX_BITS);
            // Product is sign-corrected once, on the way into DONE, and held there.
            if (calc_last)
                out_p <= neg ? -acc_nxt : acc_nxt;
        end
    end
endmodule

// File: tb/tb_pipe_int_mul_varlat.sv
// Directed and random checks for pipe_int_mul_varlat at default parameters.
module tb_pipe_int_mul_varlat;
    localparam int W     = 32;
    localparam int STEPS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_signed = 1'b0;
    logic          out_val;
    logic          out_rdy = 1'b1;
    logic [2*W-1:0] out_p;

    int checks = 0;
    int errors = 0;

    pipe_int_mul_varlat #(.WIDTH(W), .RADIX_BITS(2)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_val(out_val), .out_rdy(out_rdy), .out_p(out_p)
    );

    always #5 clk = ~clk;

    // Edges from accept (accept edge counted as 1) to out_val.
    function automatic int exp_lat(input int k);
`ifdef PIPE_INT_MUL_EARLY_TERM_EN
        return k + 1;
`else
        return STEPS + 1;
`endif
    endfunction

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] r;
        if (s) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else   r = {32'b0, a} * {32'b0, b};
        return r;
    endfunction

    // Drives one request with out_rdy=1 and returns product, latency and timeout flag.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] p, output int lat, output bit to);
        int guard = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_signed = s; in_val = 1'b1; out_rdy = 1'b1;
        while (!in_rdy && guard < 100) begin
            @(negedge clk); guard++;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_val = 1'b0;
        while (!out_val && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        p  = out_p;
        to = !out_val || guard >= 100;
        @(posedge clk);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (out_val !== 1'b0 || out_p !== 64'h0) begin
            errors++; $display("FAIL reset_outputs out_val=%b out_p=%h want 0/0", out_val, out_p);
        end
        @(negedge clk); reset = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            errors++; $display("FAIL reset_release in_rdy=%b out_val=%b want 1/0", in_rdy, out_val);
        end
    endtask

    task automatic test_basic;
        logic [63:0] p; int lat; bit to;
        do_op(32'd3, 32'd5, 1'b0, p, lat, to);
        checks++;
        if (to || p !== 64'h000000000000000F) begin
            errors++; $display("FAIL basic_3x5 p=%h to=%0d want 000000000000000f", p, to);
        end
        checks++;
        if (lat !== exp_lat(2)) begin
            errors++; $display("FAIL basic_lat lat=%0d want %0d", lat, exp_lat(2));
        end
    endtask

    task automatic test_signed;
        logic [63:0] p; int lat; bit to;
        do_op(32'hFFFFFFF9, 32'd6, 1'b1, p, lat, to);
        checks++;
        if (to || p !== 64'hFFFFFFFFFFFFFFD6) begin
            errors++; $display("FAIL signed_m7x6 p=%h want ffffffffffffffd6", p);
        end
        checks++;
        if (lat !== exp_lat(2)) begin
            errors++; $display("FAIL signed_lat lat=%0d want %0d", lat, exp_lat(2));
        end
        do_op(32'hFFFFFFF9, 32'd6, 1'b0, p, lat, to);
        checks++;
        if (to || p !== 64'h00000005FFFFFFD6) begin
            errors++; $display("FAIL unsigned_fff9x6 p=%h want 00000005ffffffd6", p);
        end
    endtask

    task automatic test_extremes;
        logic [63:0] p; int lat; bit to;
        do_op(32'h80000000, 32'h80000000, 1'b1, p, lat, to);
        checks++;
        if (to || p !== 64'h4000000000000000) begin
            errors++; $display("FAIL signed_min_sq p=%h want 4000000000000000", p);
        end
        checks++;
        if (lat !== 17) begin
            errors++; $display("FAIL signed_min_lat lat=%0d want 17", lat);
        end
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, to);
        checks++;
        if (to || p !== 64'hFFFFFFFE00000001) begin
            errors++; $display("FAIL unsigned_max_sq p=%h want fffffffe00000001", p);
        end
        checks++;
        if (lat !== 17) begin
            errors++; $display("FAIL unsigned_max_lat lat=%0d want 17", lat);
        end
    endtask

    task automatic test_zero;
        logic [63:0] p; int lat; bit to;
        do_op(32'h12345678, 32'd0, 1'b0, p, lat, to);
        checks++;
        if (to || p !== 64'h0) begin
            errors++; $display("FAIL zero_b p=%h want 0", p);
        end
        checks++;
        if (lat !== exp_lat(1)) begin
            errors++; $display("FAIL zero_lat lat=%0d want %0d", lat, exp_lat(1));
        end
    endtask

    task automatic test_backpressure;
        int guard = 0;
        bit bad = 0;
        @(negedge clk);
        in_a = 32'd3; in_b = 32'd5; in_signed = 1'b0; in_val = 1'b1; out_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'd2; in_b = 32'd3;
        while (!out_val && guard < 100) begin
            @(negedge clk); guard++;
        end
        checks++;
        if (!out_val) begin
            errors++; $display("FAIL bp_wait out_val=%b want 1", out_val);
        end
        for (int i = 0; i < 5; i++) begin
            if (out_val !== 1'b1 || in_rdy !== 1'b0 || out_p !== 64'hF) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold out_val=%b in_rdy=%b out_p=%h want 1/0/f", out_val, in_rdy, out_p);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_one_hs out_val=%b in_rdy=%b want 0/1", out_val, in_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_next_accept in_rdy=%b want 0", in_rdy);
        end
        in_val = 1'b0;
        guard = 0;
        while (!out_val && guard < 100) begin
            @(negedge clk); guard++;
        end
        checks++;
        if (out_val !== 1'b1 || out_p !== 64'd6) begin
            errors++; $display("FAIL bp_next_result out_val=%b out_p=%h want 1/6", out_val, out_p);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid;
        logic [63:0] p; int lat; bit to;
        bit seen = 0;
        @(negedge clk);
        in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_signed = 1'b0; in_val = 1'b1; out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk); in_val = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        checks++;
        if (out_val !== 1'b0 || out_p !== 64'h0) begin
            errors++; $display("FAIL mid_reset out_val=%b out_p=%h want 0/0", out_val, out_p);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_reset_rdy in_rdy=%b want 1", in_rdy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_val) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL mid_reset_no_resp out_val seen=1 want 0");
        end
        do_op(32'd2, 32'd3, 1'b0, p, lat, to);
        checks++;
        if (to || p !== 64'd6) begin
            errors++; $display("FAIL mid_reset_after p=%h want 6", p);
        end
    endtask

    task automatic test_random;
        logic [63:0] q[$];
        logic [63:0] exp, op;
        int sent = 0, rcvd = 0, cyc = 0;
        bit ihs, ohs;
        while ((sent < 200 || rcvd < sent) && cyc < 20000) begin
            @(negedge clk); cyc++;
            if (!in_val && sent < 200 && $urandom_range(0, 3) != 0) begin
                in_a = $urandom;
                in_b = $urandom;
                if ($urandom_range(0, 2) == 0) in_b = in_b >> $urandom_range(0, 31);
                in_signed = 1'($urandom_range(0, 1));
                in_val = 1'b1;
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            ihs = in_val && in_rdy;
            ohs = out_val && out_rdy;
            op  = out_p;
            if (ihs) q.push_back(model(in_a, in_b, in_signed));
            @(posedge clk);
            if (ohs) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious p=%h want no response", op);
                end else begin
                    exp = q.pop_front();
                    if (op !== exp) begin
                        errors++; $display("FAIL rand_p n=%0d p=%h want %h", rcvd, op, exp);
                    end
                end
                rcvd++;
            end
            if (ihs) begin
                sent++;
                #1 in_val = 1'b0;
            end
        end
        in_val = 1'b0; out_rdy = 1'b1;
        checks++;
        if (sent !== 200 || rcvd !== sent) begin
            errors++; $display("FAIL rand_count sent=%0d rcvd=%0d want 200/200", sent, rcvd);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_extremes;
        test_zero;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_int_mul_varlat.md
Name: pipe_int_mul_varlat

Overview:
- Parametrised, variable-latency integer multiplier; successor to the fixed 32x32 pipelined multiplier core.
- Iterative radix-2^RADIX_BITS shift-add datapath with selectable signed/unsigned operation and early termination on short multipliers.
- Full valid/ready handshake on both request and response sides, so a stalled consumer backpressures the producer.
- Drops into the existing source/sink bench style: request {a,b}, response {p}.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- RADIX_BITS, 2, multiplier bits consumed per CALC cycle; WIDTH must be a multiple of RADIX_BITS (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_val  input  1  request valid.
- in_rdy  output  1  request ready.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- out_val  output  1  response valid.
- out_rdy  input  1  response ready.
- out_p  output  2*WIDTH  product.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; in_rdy=1 once released; out_val=0; out_p=0; all internal registers cleared. Any in-flight operation is discarded, with no partial response.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&in_rdy at an edge, latch |a|, |b|, neg = in_signed & (a[W-1]^b[W-1]), acc=0, shift=0, then go to CALC.
  - in_signed is sampled only at accept.
- Magnitudes:
  - Unsigned: operand as-is.
  - Signed: negate if MSB=1. -2^(W-1) maps to magnitude 2^(W-1), which fits in WIDTH bits unsigned.
- CALC, per edge:
  - acc += (|a| * b[RADIX_BITS-1:0]) << shift.
  - b >>= RADIX_BITS; shift += RADIX_BITS.
  - Go to DONE when the shifted b == 0 (early termination), else stay in CALC.
  - acc is 2*WIDTH bits and never overflows.
  - in_rdy=0, out_val=0.
- CALC cycle count k:
  - k = max(1, ceil(bitlen(|b|)/RADIX_BITS)).
  - b=0 gives k=1.
  - Maximum k is WIDTH/RADIX_BITS.
- DONE:
  - out_val=1; out_p = neg ? -acc : acc (2*WIDTH two's complement), registered and stable while out_val=1.
  - in_rdy=0, so in_val is ignored.
  - On out_val&out_rdy, go to IDLE.
- Latency: out_val asserts k+1 rising edges after the accept edge. Throughput is one operation per k+2 cycles minimum when out_rdy=1.
- Backpressure: with out_rdy=0, remain in DONE indefinitely with out_p held; no further request is accepted.
- out_rdy asserted while not in DONE has no effect.
- Reset asserted mid-CALC or mid-DONE: immediate return to IDLE, out_val=0.

Optional Feature:
- Macro: PIPE_INT_MUL_EARLY_TERM_EN.
- Defined: early termination as described above; latency depends on the data.
- Undefined:
  - CALC always runs exactly WIDTH/RADIX_BITS cycles regardless of b.
  - A down-counter drives the DONE transition.
  - Fixed latency of WIDTH/RADIX_BITS+1 edges (17 at defaults).
  - Results are identical in both builds.

Test Plan:
- Defaults, unsigned, a=3, b=5, out_rdy=1 -> out_p=0x000000000000000F.
  - Early-term build: out_val 3 edges after accept (k=2).
  - Fixed build: out_val after 17 edges.
- Signed, a=0xFFFFFFF9 (-7), b=6 -> out_p=0xFFFFFFFFFFFFFFD6 (-42), k=2. The same operands with in_signed=0 -> 0x00000005FFFFFFD6.
- Extremes:
  - Signed 0x80000000*0x80000000 -> 0x4000000000000000.
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001.
  - Both cases k=16, out_val after 17 edges.
- b=0, a=0x12345678 -> out_p=0, k=1, out_val 2 edges after accept.
- Backpressure: hold out_rdy=0 for 5 cycles after out_val and keep in_val=1 with new operands.
  - out_val stays 1, out_p stays stable, in_rdy stays 0, and the new request is not accepted.
  - On out_rdy=1, exactly one handshake occurs; the next request is accepted in IDLE on the following edge.
- Drop reset to 0 during CALC of 0xFFFFFFFF*0xFFFFFFFF -> out_val=0 immediately and no response is ever produced. After release, in_rdy=1 and a subsequent 2*3 returns 6.
- Random sweep: 200 requests with random in_signed, in_val and out_rdy gaps; compare against a reference model in order; response count equals request count.
